localbus_master_ctrl: RTL and testbench

Configuration master for the lookup pipeline's local bus. Accepts one register read/write command at a time from the control plane over a valid/ready handshake. Sequences the localbus address-latch / chip-select / acknowledge protocol toward the lookup block, whose address bits [18:16] select the search engine. Returns read data or a timeout indication as a single-cycle response.

---
 rtl/lb_pkg.sv | 26 ++
 rtl/lb_wait_timer.sv | 30 +++
 rtl/localbus_master_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_localbus_master_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lb_pkg.sv
// Shared types and constants for the lookup-pipeline localbus master.
// Holds the FSM state encoding, bus direction encodings and engine-select field.
// No logic; imported by the controller and its wait timer.
package lb_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ADDR    = 3'd1,
      SETUP   = 3'd2,
      ACCESS  = 3'd3,
      RELEASE = 3'd4,
      RESP    = 3'd5
   } lb_state_e;

   localparam logic LB_RD = 1'b1;
   localparam logic LB_WR = 1'b0;

   // Address bits [18:16] pick the search engine inside the lookup block.
   localparam int ENGINE_SEL_LSB = 16;
   localparam int ENGINE_SEL_W   = 3;

   function automatic logic [ENGINE_SEL_W-1:0] engine_sel(input logic [31:0] addr);
      return addr[ENGINE_SEL_LSB +: ENGINE_SEL_W];
   endfunction

endpackage

// File: rtl/lb_wait_timer.sv
// Wait counter shared by the ACCESS and RELEASE phases of a localbus cycle.
// Latency: expiry flag is combinational from the count register.
// Backpressure: none; clear has priority over enable.
module lb_wait_timer #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_W          = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   logic [CNT_W-1:0] cnt_q;

   // Count waited cycles; restart whenever a new wait phase begins.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (en_i) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign expired_o = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/localbus_master_ctrl.sv
// Localbus master: one register command at a time, ALE/CS/ACK sequencing, timeout.
// Latency: 5 cycles minimum from acceptance to the one-cycle response pulse.
// Backpressure: cmd_ready only in IDLE; response has no backpressure.
module localbus_master_ctrl
   import lb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_W          = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_rd,
   input  logic [31:0] cmd_addr,
   input  logic [31:0] cmd_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_timeout,
   output logic [15:0] err_cnt,
   output logic        localbus_cs_n,
   output logic        localbus_rd_wr,
   output logic [31:0] localbus_data,
   output logic        localbus_ale,
   input  logic        localbus_ack_n,
   input  logic [31:0] localbus_data_out
);

   lb_state_e   state_q, state_d;
   logic        rd_q, rd_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        to_q, to_d;
   logic        tmr_clr, tmr_en, tmr_exp;

   logic        cs_n_q, cs_n_d;
   logic        ale_q, ale_d;
   logic        rd_wr_q, rd_wr_d;
   logic [31:0] data_q, data_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic        rsp_timeout_q, rsp_timeout_d;
   logic [31:0] rsp_rdata_q, rsp_rdata_d;
   logic [15:0] err_cnt_q, err_cnt_d;

   lb_wait_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
      .CNT_W         (CNT_W)
   ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .clr_i    (tmr_clr),
      .en_i     (tmr_en),
      .expired_o(tmr_exp)
   );

   assign cmd_ready = (state_q == IDLE);

   // State and latched command/result registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         rd_q    <= LB_RD;
         wdata_q <= '0;
         rdata_q <= '0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         rd_q    <= rd_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         to_q    <= to_d;
      end
   end

   // Next-state logic: ack_n is only looked at from the first ACCESS cycle on.
   always_comb begin
      state_d = state_q;
      rd_d    = rd_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      to_d    = to_q;
      tmr_clr = 1'b0;
      tmr_en  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               rd_d    = cmd_rd;
               wdata_d = cmd_wdata;
               rdata_d = '0;
               to_d    = 1'b0;
               state_d = ADDR;
            end
         end
         ADDR: state_d = SETUP;
         SETUP: begin
            tmr_clr = 1'b1;
            state_d = ACCESS;
         end
         ACCESS: begin
            if (!localbus_ack_n) begin
               rdata_d = (rd_q == LB_RD) ? localbus_data_out : '0;
               tmr_clr = 1'b1;
               state_d = RELEASE;
            end else if (tmr_exp) begin
               to_d    = 1'b1;
               rdata_d = '0;
               state_d = RELEASE;
            end else begin
               tmr_en = 1'b1;
            end
         end
         RELEASE: begin
            if (to_q || localbus_ack_n) begin
               state_d = RESP;
            end else if (tmr_exp) begin
               to_d    = 1'b1;
               rdata_d = '0;
               state_d = RESP;
            end else begin
               tmr_en = 1'b1;
            end
         end
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output decode from the next state so every bus/response pin leaves a flop.
   always_comb begin
      cs_n_d        = (state_d != ACCESS);
      ale_d         = (state_d == ADDR);
      rd_wr_d       = (state_d == ACCESS) ? rd_d : LB_RD;
      data_d        = '0;
      rsp_valid_d   = (state_d == RESP);
      rsp_timeout_d = (state_d == RESP) && to_d;
      rsp_rdata_d   = (state_d == RESP) ? rdata_d : '0;
      err_cnt_d     = err_cnt_q;
      // The address is only live on cmd_addr in the accept cycle, so the
      // bus data register itself is what holds it through ADDR.
      if (state_d == ADDR) begin
         data_d = cmd_addr;
      end else if (state_d == ACCESS && rd_d == LB_WR) begin
         data_d = wdata_d;
      end
      if (rsp_timeout_d && err_cnt_q != 16'hFFFF) begin
         err_cnt_d = err_cnt_q + 16'd1;
      end
   end

   // Output registers; reset drops chip select immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cs_n_q        <= 1'b1;
         ale_q         <= 1'b0;
         rd_wr_q       <= LB_RD;
         data_q        <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_timeout_q <= 1'b0;
         rsp_rdata_q   <= '0;
         err_cnt_q     <= '0;
      end else begin
         cs_n_q        <= cs_n_d;
         ale_q         <= ale_d;
         rd_wr_q       <= rd_wr_d;
         data_q        <= data_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_timeout_q <= rsp_timeout_d;
         rsp_rdata_q   <= rsp_rdata_d;
         err_cnt_q     <= err_cnt_d;
      end
   end

   assign localbus_cs_n  = cs_n_q;
   assign localbus_ale   = ale_q;
   assign localbus_rd_wr = rd_wr_q;
   assign localbus_data  = data_q;
   assign rsp_valid      = rsp_valid_q;
   assign rsp_timeout    = rsp_timeout_q;
   assign rsp_rdata      = rsp_rdata_q;
   assign err_cnt        = err_cnt_q;

endmodule

// File: tb/tb_localbus_master_ctrl.sv
// Directed bench for localbus_master_ctrl with a short timeout (4 cycles).
// A behavioural slave answers with a per-vector ack delay / release hold.
// All DUT outputs are sampled and all inputs driven on the falling edge.
module tb_localbus_master_ctrl;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_rd;
   logic [31:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_timeout;
   logic [15:0] err_cnt;
   logic        localbus_cs_n;
   logic        localbus_rd_wr;
   logic [31:0] localbus_data;
   logic        localbus_ale;
   logic        localbus_ack_n = 1'b1;
   logic [31:0] localbus_data_out = 32'hFFFF_FFFF;

   always #5 clk = ~clk;

   localbus_master_ctrl #(
      .TIMEOUT_CYCLES(TO),
      .CNT_W         (3)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .cmd_valid        (cmd_valid),
      .cmd_ready        (cmd_ready),
      .cmd_rd           (cmd_rd),
      .cmd_addr         (cmd_addr),
      .cmd_wdata        (cmd_wdata),
      .rsp_valid        (rsp_valid),
      .rsp_rdata        (rsp_rdata),
      .rsp_timeout      (rsp_timeout),
      .err_cnt          (err_cnt),
      .localbus_cs_n    (localbus_cs_n),
      .localbus_rd_wr   (localbus_rd_wr),
      .localbus_data    (localbus_data),
      .localbus_ale     (localbus_ale),
      .localbus_ack_n   (localbus_ack_n),
      .localbus_data_out(localbus_data_out)
   );

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
      end
   endtask

   // Slave model: ack after sl_delay chip-select cycles, keep ack low for
   // sl_hold cycles after cs_n rises, optionally drive a stale low ack early.
   int          sl_delay = 0;
   int          sl_hold  = 0;
   bit          sl_stale = 0;
   logic [31:0] sl_rdata = '0;
   int          sl_n = 0;
   int          sl_h = 0;

   always @(negedge clk) begin
      if (reset || rsp_valid) begin
         sl_n = 0;
         sl_h = 0;
         localbus_ack_n = 1'b1;
      end else if (!localbus_cs_n) begin
         sl_n++;
         localbus_ack_n = (sl_n > sl_delay) ? 1'b0 : 1'b1;
      end else if (sl_n > 0) begin
         sl_h++;
         localbus_ack_n = (sl_h <= sl_hold) ? 1'b0 : 1'b1;
      end else begin
         localbus_ack_n = sl_stale ? 1'b0 : 1'b1;
      end
      localbus_data_out = (!localbus_cs_n && sl_n > sl_delay) ? sl_rdata : 32'hFFFF_FFFF;
   end

   typedef struct {
      logic        rd;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] slave_rdata;
      int          delay;
      int          hold;
      bit          stale;
      int          lat;
      int          cs_low;
      logic        to;
      logic [31:0] rdata;
      logic [15:0] err;
   } vec_t;

   vec_t vecs[8];

   // Called just after a falling edge with the DUT idle; returns one cycle
   // after the response pulse (again just after a falling edge).
   task automatic run_txn(input vec_t v, input string tag);
      int          lat, cs_low, ale_cnt;
      logic [31:0] ale_dat, acc_dat, rdat;
      logic        acc_rw, rto, overlap, ready_early, got;
      logic [15:0] err;
      lat = -1; cs_low = 0; ale_cnt = 0; ale_dat = '0; acc_dat = '0; rdat = '0;
      acc_rw = 1'b1; rto = 1'b0; overlap = 1'b0; ready_early = 1'b0; got = 1'b0; err = '0;
      check({tag, ".ready_before"}, 32'(cmd_ready), 32'd1);
      sl_delay = v.delay; sl_hold = v.hold; sl_stale = v.stale; sl_rdata = v.slave_rdata;
      cmd_valid = 1'b1; cmd_rd = v.rd; cmd_addr = v.addr; cmd_wdata = v.wdata;
      for (int k = 1; k <= 30 && !got; k++) begin
         @(negedge clk);
         if (k == 1) cmd_valid = 1'b0;
         if (localbus_ale) begin
            ale_cnt++;
            ale_dat = localbus_data;
         end
         if (!localbus_cs_n) begin
            if (cs_low == 0) begin
               acc_dat = localbus_data;
               acc_rw  = localbus_rd_wr;
            end
            cs_low++;
         end
         if (localbus_ale && !localbus_cs_n) overlap = 1'b1;
         if (cmd_ready) ready_early = 1'b1;
         if (rsp_valid) begin
            got = 1'b1; lat = k; rto = rsp_timeout; rdat = rsp_rdata; err = err_cnt;
         end
      end
      check({tag, ".latency"},   32'(lat),     32'(v.lat));
      check({tag, ".timeout"},   32'(rto),     32'(v.to));
      check({tag, ".rdata"},     rdat,         v.rdata);
      check({tag, ".err_cnt"},   32'(err),     32'(v.err));
      check({tag, ".cs_low"},    32'(cs_low),  32'(v.cs_low));
      check({tag, ".ale_cyc"},   32'(ale_cnt), 32'd1);
      check({tag, ".ale_data"},  ale_dat,      v.addr);
      check({tag, ".acc_data"},  acc_dat,      v.rd ? 32'h0 : v.wdata);
      check({tag, ".acc_rd_wr"}, 32'(acc_rw),  32'(v.rd));
      check({tag, ".overlap"},   32'(overlap), 32'd0);
      check({tag, ".ready_busy"}, 32'(ready_early), 32'd0);
      @(negedge clk);
      check({tag, ".rsp_pulse"}, 32'(rsp_valid), 32'd0);
      check({tag, ".ready_after"}, 32'(cmd_ready), 32'd1);
   endtask

   initial begin
      //          rd    addr          wdata         slave_rdata   dly hld stl lat cs to    rdata         err
      vecs[0] = '{1'b0, 32'h0001_0004, 32'hDEAD_BEEF, 32'hCAFE_0001, 1,  0, 0, 6, 2, 1'b0, 32'h0,         16'd0};
      vecs[1] = '{1'b1, 32'h0000_0010, 32'h0,         32'h1234_5678, 3,  0, 0, 8, 4, 1'b0, 32'h1234_5678, 16'd0};
      vecs[2] = '{1'b1, 32'h0007_0020, 32'h0,         32'h9999_9999, 99, 0, 0, 8, 4, 1'b1, 32'h0,         16'd1};
      vecs[3] = '{1'b1, 32'h0005_0000, 32'h0,         32'hA5A5_0F0F, 0,  0, 0, 5, 1, 1'b0, 32'hA5A5_0F0F, 16'd1};
      vecs[4] = '{1'b0, 32'h0003_0100, 32'h0BAD_CAFE, 32'hCAFE_0002, 99, 0, 0, 8, 4, 1'b1, 32'h0,         16'd2};
      vecs[5] = '{1'b1, 32'h0002_0008, 32'h0,         32'h0BAD_F00D, 2,  0, 1, 7, 3, 1'b0, 32'h0BAD_F00D, 16'd2};
      vecs[6] = '{1'b1, 32'h0006_0040, 32'h0,         32'h0000_7777, 0,  2, 0, 7, 1, 1'b0, 32'h0000_7777, 16'd2};
      vecs[7] = '{1'b1, 32'h0004_0044, 32'h0,         32'h0000_0077, 0, 99, 0, 8, 1, 1'b1, 32'h0,         16'd3};

      reset = 1'b1; cmd_valid = 1'b0; cmd_rd = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      repeat (2) @(negedge clk);
      check("rst.cs_n",      32'(localbus_cs_n),  32'd1);
      check("rst.ale",       32'(localbus_ale),   32'd0);
      check("rst.rd_wr",     32'(localbus_rd_wr), 32'd1);
      check("rst.data",      localbus_data,       32'h0);
      check("rst.rsp_valid", 32'(rsp_valid),      32'd0);
      check("rst.rsp_to",    32'(rsp_timeout),    32'd0);
      check("rst.rsp_rdata", rsp_rdata,           32'h0);
      check("rst.err_cnt",   32'(err_cnt),        32'd0);
      check("rst.ready",     32'(cmd_ready),      32'd1);
      reset = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 8; i++) begin
         run_txn(vecs[i], $sformatf("vec%0d", i));
      end

      // Back-to-back: valid stays high across two commands.
      begin
         int          r1, r2, a2, nale;
         logic [31:0] d1, d2;
         logic        ovl, rto2;
         r1 = -1; r2 = -1; a2 = -1; nale = 0; d1 = '0; d2 = '1; ovl = 1'b0; rto2 = 1'b1;
         sl_delay = 0; sl_hold = 0; sl_stale = 0; sl_rdata = 32'h1111_2222;
         cmd_valid = 1'b1; cmd_rd = 1'b1; cmd_addr = 32'h0003_0000; cmd_wdata = '0;
         for (int k = 1; k <= 30 && r2 < 0; k++) begin
            @(negedge clk);
            if (k == 1) begin
               cmd_rd = 1'b0; cmd_addr = 32'h0004_0004; cmd_wdata = 32'h55AA_55AA;
            end
            if (localbus_ale) begin
               nale++;
               if (nale == 2) begin
                  a2 = k;
                  cmd_valid = 1'b0;
               end
            end
            if (localbus_ale && !localbus_cs_n) ovl = 1'b1;
            if (rsp_valid) begin
               if (r1 < 0) begin
                  r1 = k; d1 = rsp_rdata;
               end else begin
                  r2 = k; d2 = rsp_rdata; rto2 = rsp_timeout;
               end
            end
         end
         check("b2b.rsp1_cycle", 32'(r1), 32'd5);
         check("b2b.rsp1_rdata", d1, 32'h1111_2222);
         check("b2b.ale2_cycle", 32'(a2), 32'd7);
         check("b2b.rsp2_cycle", 32'(r2), 32'd11);
         check("b2b.rsp2_rdata", d2, 32'h0);
         check("b2b.rsp2_to",    32'(rto2), 32'd0);
         check("b2b.overlap",    32'(ovl), 32'd0);
         @(negedge clk);
      end

      // Reset during ACCESS: immediate abort, no response, clean restart.
      begin
         logic saw_rsp, not_ready, cs_act;
         saw_rsp = 1'b0; not_ready = 1'b0; cs_act = 1'b0;
         sl_delay = 99; sl_hold = 0; sl_stale = 0; sl_rdata = 32'h0;
         cmd_valid = 1'b1; cmd_rd = 1'b1; cmd_addr = 32'h0001_0000;
         repeat (4) @(negedge clk);
         cmd_valid = 1'b0;
         check("rstmid.in_access", 32'(localbus_cs_n), 32'd0);
         reset = 1'b1;
         #1;
         check("rstmid.cs_n",    32'(localbus_cs_n), 32'd1);
         check("rstmid.ale",     32'(localbus_ale),  32'd0);
         check("rstmid.err_cnt", 32'(err_cnt),       32'd0);
         @(negedge clk);
         reset = 1'b0;
         for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (rsp_valid) saw_rsp = 1'b1;
            if (!cmd_ready) not_ready = 1'b1;
            if (!localbus_cs_n) cs_act = 1'b1;
         end
         check("rstmid.no_rsp",   32'(saw_rsp),   32'd0);
         check("rstmid.ready",    32'(not_ready), 32'd0);
         check("rstmid.cs_quiet", 32'(cs_act),    32'd0);
      end

      run_txn(vecs[0], "post_rst");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
